// File: rtl/am_popcount_accum.sv
// Per-class similarity accumulator for the associative memory.
// Each accepted chunk is popcounted through a balanced adder tree. When
// TREE_PIPE=1 the popcount is registered before it is added. The popcounts of
// all chunks are summed, and the total is held with sim_valid for the argmax
// stage.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start; accumulator is zero or holds nothing useful
// ACCUM  | chunk_ready high; accepted chunks are counted and summed
// DRAIN  | TREE_PIPE=1 only; the registered final partial sum is added
// DONE   | similarity_value and count_err held, sim_valid high

module am_popcount_accum #(
    parameter  int DIMS_PER_CC = 500,
    parameter  int NUM_CHUNKS  = 10,
    parameter  int TREE_PIPE   = 1,
    localparam int PS_W        = $clog2(DIMS_PER_CC + 1),
    localparam int SIM_W       = $clog2(DIMS_PER_CC * NUM_CHUNKS + 1),
    localparam int CNT_W       = $clog2(NUM_CHUNKS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   clear,
    input  logic                   chunk_valid,
    input  logic                   chunk_last,
    input  logic [DIMS_PER_CC-1:0] chunk_data,
    output logic                   chunk_ready,
    output logic                   busy,
    output logic                   sim_valid,
    output logic [SIM_W-1:0]       similarity_value,
    output logic                   count_err
);

    // The tree is built over a power-of-two leaf count. Leaves past
    // DIMS_PER_CC are tied to zero, so they do not change the sum.
    localparam int LEVELS = $clog2(DIMS_PER_CC);
    localparam int P2     = 1 << LEVELS;

    // Bit offset of tree level l in the flat node bus. Level j has P2>>j
    // nodes, and each node is j+1 bits wide.
    function automatic int lvl_off(input int l);
        int acc;
        acc = 0;
        for (int j = 0; j < l; j++) begin
            acc += (P2 >> j) * (j + 1);
        end
        return acc;
    endfunction

    localparam int TREE_BITS = lvl_off(LEVELS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [TREE_BITS-1:0] tree_bus;
    logic [PS_W-1:0]    pop_cnt;
    logic [SIM_W-1:0]   addend;
    logic               accept;
    logic               at_last_cnt;
    logic               finish_chunk;
    logic               early_last;
    logic               overrun;

    genvar l, n;
    generate
        for (l = 0; l <= LEVELS; l++) begin : g_lvl
            for (n = 0; n < (P2 >> l); n++) begin : g_node
                if (l == 0) begin : g_leaf
                    if (n < DIMS_PER_CC) begin : g_bit
                        assign tree_bus[lvl_off(0) + n] = chunk_data[n];
                    end else begin : g_pad
                        assign tree_bus[lvl_off(0) + n] = 1'b0;
                    end
                end else begin : g_add
                    // Each level is one bit wider than the one below it, so a node never overflows.
                    assign tree_bus[lvl_off(l) + n*(l+1) +: l+1] =
                        {1'b0, tree_bus[lvl_off(l-1) + (2*n)*l   +: l]} +
                        {1'b0, tree_bus[lvl_off(l-1) + (2*n+1)*l +: l]};
                end
            end
        end
    endgenerate

    // The root is one bit wider than a chunk popcount can need when
    // DIMS_PER_CC is not a power of two. The extra bit is always zero.
    assign pop_cnt = PS_W'(tree_bus[lvl_off(LEVELS) +: LEVELS+1]);

    // A chunk that arrives in the same cycle as start or clear is dropped.
    assign accept       = chunk_valid & chunk_ready & ~start & ~clear;
    assign at_last_cnt  = (cnt == CNT_W'(NUM_CHUNKS - 1));
    assign finish_chunk = accept & (chunk_last | at_last_cnt);
    assign early_last   = accept & chunk_last & ~at_last_cnt;
    assign overrun      = accept & ~chunk_last & at_last_cnt;

    generate
        if (TREE_PIPE != 0) begin : g_pipe
            logic [PS_W-1:0] pipe_q;

            // Partial-sum register. It loads zero on any cycle without an
            // accepted chunk, so gaps and DRAIN add nothing twice.
            always_ff @(posedge clk) begin
                if (rst || clear || start) begin
                    pipe_q <= '0;
                end else if (accept) begin
                    pipe_q <= pop_cnt;
                end else begin
                    pipe_q <= '0;
                end
            end

            assign addend = SIM_W'(pipe_q);
        end else begin : g_comb
            assign addend = accept ? SIM_W'(pop_cnt) : '0;
        end
    endgenerate

    // Sequencing FSM, with the accumulator, chunk counter and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            similarity_value <= '0;
            cnt              <= '0;
            count_err        <= 1'b0;
            chunk_ready      <= 1'b0;
            busy             <= 1'b0;
            sim_valid        <= 1'b0;
        end else if (clear) begin
            state            <= S_IDLE;
            similarity_value <= '0;
            cnt              <= '0;
            count_err        <= 1'b0;
            chunk_ready      <= 1'b0;
            busy             <= 1'b0;
            sim_valid        <= 1'b0;
        end else if (start) begin
            state            <= S_ACCUM;
            similarity_value <= '0;
            cnt              <= '0;
            count_err        <= 1'b0;
            chunk_ready      <= 1'b1;
            busy             <= 1'b1;
            sim_valid        <= 1'b0;
        end else begin
            case (state)
                S_ACCUM: begin
                    similarity_value <= similarity_value + addend;
                    if (accept) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                    if (early_last || overrun) begin
                        count_err <= 1'b1;
                    end
                    if (finish_chunk) begin
                        chunk_ready <= 1'b0;
                        if (TREE_PIPE != 0) begin
                            state <= S_DRAIN;
                        end else begin
                            state     <= S_DONE;
                            busy      <= 1'b0;
                            sim_valid <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    similarity_value <= similarity_value + addend;
                    state            <= S_DONE;
                    busy             <= 1'b0;
                    sim_valid        <= 1'b1;
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                S_IDLE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state       <= S_IDLE;
                    chunk_ready <= 1'b0;
                    busy        <= 1'b0;
                    sim_valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule
